// File: rtl/branch_predictor.sv
// Branch target buffer + pattern history table for the 5-stage pipeline.
// Combinational lookup on the IF PC; resolved outcomes from ID train the table and repair the GHR.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int GSHARE  = 0,
    parameter int GHR_W   = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      lk_pc_i,
    output logic             lk_hit_o,
    output logic             lk_taken_o,
    output logic [31:0]      lk_target_o,
    output logic [GHR_W-1:0] lk_ghr_o,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic [GHR_W-1:0] upd_ghr_i,
    input  logic             upd_is_jump_i,
    input  logic             upd_taken_i,
    input  logic [31:0]      upd_target_i,
    input  logic             upd_pred_taken_i,
    input  logic [31:0]      upd_pred_target_i,
    output logic             mispredict_o,
    output logic [31:0]      stat_lookups_o,
    output logic [31:0]      stat_mispred_o
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CNT_W-1:0] cnt;
    } entry_t;

    entry_t           r_tbl [ENTRIES];
    logic [GHR_W-1:0] r_ghr;
    logic [31:0]      r_stat_lookups;
    logic [31:0]      r_stat_mispred;

    // Zero-pad the histories so a short GHR still yields IDX_W index bits.
    logic [GHR_W+IDX_W-1:0] w_lk_hpad, w_upd_hpad;
    logic [IDX_W-1:0]       w_lk_idx, w_upd_idx;
    logic [TAG_W-1:0]       w_lk_tag, w_upd_tag;
    entry_t                 w_lk_ent, w_upd_ent;
    logic                   w_upd_hit;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [GHR_W:0]         w_ghr_shift;
    logic                   w_unused;

    assign w_lk_hpad  = {{IDX_W{1'b0}}, r_ghr};
    assign w_upd_hpad = {{IDX_W{1'b0}}, upd_ghr_i};

    assign w_lk_idx  = lk_pc_i[IDX_W+1:2]  ^ ((GSHARE != 0) ? w_lk_hpad[IDX_W-1:0]  : '0);
    assign w_upd_idx = upd_pc_i[IDX_W+1:2] ^ ((GSHARE != 0) ? w_upd_hpad[IDX_W-1:0] : '0);
    assign w_lk_tag  = lk_pc_i[TAG_LO+TAG_W-1:TAG_LO];
    assign w_upd_tag = upd_pc_i[TAG_LO+TAG_W-1:TAG_LO];

    assign w_lk_ent  = r_tbl[w_lk_idx];
    assign w_upd_ent = r_tbl[w_upd_idx];

    assign lk_hit_o    = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
    assign lk_taken_o  = lk_hit_o && w_lk_ent.cnt[CNT_W-1];
    assign lk_target_o = lk_taken_o ? w_lk_ent.target : lk_pc_i + 32'd4;
    assign lk_ghr_o    = r_ghr;

    assign mispredict_o = upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    assign w_upd_hit   = w_upd_ent.valid && (w_upd_ent.tag == w_upd_tag);
    assign w_ghr_shift = {upd_ghr_i, upd_taken_i};

    always_comb begin
        w_cnt_next = w_upd_ent.cnt;
        if (upd_is_jump_i)
            w_cnt_next = CNT_MAX;
        else if (upd_taken_i && w_upd_ent.cnt != CNT_MAX)
            w_cnt_next = w_upd_ent.cnt + CNT_W'(1);
        else if (!upd_taken_i && w_upd_ent.cnt != '0)
            w_cnt_next = w_upd_ent.cnt - CNT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl[i].valid <= 1'b0;
                r_tbl[i].cnt   <= CNT_WNT;
            end
            r_ghr          <= '0;
            r_stat_lookups <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (upd_valid_i) begin
                if (w_upd_hit) begin
                    r_tbl[w_upd_idx].cnt <= w_cnt_next;
                    if (upd_taken_i)
                        r_tbl[w_upd_idx].target <= upd_target_i;
                end else if (upd_taken_i) begin
                    r_tbl[w_upd_idx].valid  <= 1'b1;
                    r_tbl[w_upd_idx].tag    <= w_upd_tag;
                    r_tbl[w_upd_idx].target <= upd_target_i;
                    r_tbl[w_upd_idx].cnt    <= upd_is_jump_i ? CNT_MAX : CNT_WT;
                end
                // History rebuilt from the instruction's own snapshot: repairs after a mispredict.
                if (!upd_is_jump_i)
                    r_ghr <= w_ghr_shift[GHR_W-1:0];
            end
            if (r_stat_lookups != '1)
                r_stat_lookups <= r_stat_lookups + 32'd1;
            if (mispredict_o && r_stat_mispred != '1)
                r_stat_mispred <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_lookups_o = r_stat_lookups;
    assign stat_mispred_o = r_stat_mispred;

    assign w_unused = ^{lk_pc_i, upd_pc_i, w_lk_hpad, w_upd_hpad, w_ghr_shift};
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal and gshare instances driven in lockstep, checked
// against a table model built directly from the prediction/training rules.
module tb_branch_predictor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] lk_pc;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic [3:0]  upd_ghr;

    logic [1:0]  hit, taken, misp;
    logic [31:0] tgt   [2];
    logic [3:0]  ghr   [2];
    logic [31:0] slook [2];
    logic [31:0] smis  [2];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        branch_predictor #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .GSHARE(k), .GHR_W(4)) u_dut (
            .clk_i(clk), .rst_i(rst), .lk_pc_i(lk_pc),
            .lk_hit_o(hit[k]), .lk_taken_o(taken[k]), .lk_target_o(tgt[k]), .lk_ghr_o(ghr[k]),
            .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr),
            .upd_is_jump_i(upd_is_jump), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
            .upd_pred_taken_i(upd_pred_taken), .upd_pred_target_i(upd_pred_target),
            .mispredict_o(misp[k]), .stat_lookups_o(slook[k]), .stat_mispred_o(smis[k]));
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: index 0 = bimodal, index 1 = gshare; counters are plain ints 0..3.
    bit          m_v   [2][16];
    int          m_tag [2][16];
    logic [31:0] m_tgt [2][16];
    int          m_cnt [2][16];
    int          m_ghr [2];
    longint      m_look[2];
    longint      m_mis [2];

    function automatic int idx_of(int k, logic [31:0] pc, int h);
        return int'((pc >> 2) % 16) ^ ((k == 1) ? (h % 16) : 0);
    endfunction

    function automatic int tag_of(logic [31:0] pc);
        return int'((pc >> 6) % 256);
    endfunction

    function automatic bit exp_mis();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && upd_target != upd_pred_target));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                m_v[k][i] = 0;
                m_cnt[k][i] = 1;
            end
            m_ghr[k] = 0; m_look[k] = 0; m_mis[k] = 0;
        end
    endtask

    task automatic model_apply();
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_look[k] < 64'hFFFF_FFFF) m_look[k]++;
            if (exp_mis() && m_mis[k] < 64'hFFFF_FFFF) m_mis[k]++;
            if (upd_valid) begin
                int i;
                i = idx_of(k, upd_pc, int'(upd_ghr));
                if (m_v[k][i] && m_tag[k][i] == tag_of(upd_pc)) begin
                    if (upd_is_jump)    m_cnt[k][i] = 3;
                    else if (upd_taken) m_cnt[k][i] = (m_cnt[k][i] < 3) ? m_cnt[k][i] + 1 : 3;
                    else                m_cnt[k][i] = (m_cnt[k][i] > 0) ? m_cnt[k][i] - 1 : 0;
                    if (upd_taken) m_tgt[k][i] = upd_target;
                end else if (upd_taken) begin
                    m_v[k][i] = 1;
                    m_tag[k][i] = tag_of(upd_pc);
                    m_tgt[k][i] = upd_target;
                    m_cnt[k][i] = upd_is_jump ? 3 : 2;
                end
                if (!upd_is_jump) m_ghr[k] = (int'(upd_ghr) * 2 + int'(upd_taken)) % 16;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int i; bit eh, et; logic [31:0] etg;
            i   = idx_of(k, lk_pc, m_ghr[k]);
            eh  = m_v[k][i] && m_tag[k][i] == tag_of(lk_pc);
            et  = eh && m_cnt[k][i] >= 2;
            etg = et ? m_tgt[k][i] : lk_pc + 32'd4;
            chk($sformatf("hit%0d", k),    32'(hit[k]),   32'(eh));
            chk($sformatf("taken%0d", k),  32'(taken[k]), 32'(et));
            chk($sformatf("target%0d", k), tgt[k],        etg);
            chk($sformatf("ghr%0d", k),    32'(ghr[k]),   32'(m_ghr[k]));
            chk($sformatf("misp%0d", k),   32'(misp[k]),  32'(exp_mis()));
            chk($sformatf("slook%0d", k),  slook[k],      32'(m_look[k]));
            chk($sformatf("smis%0d", k),   smis[k],       32'(m_mis[k]));
        end
    endtask

    task automatic tick(input bit cmp);
        @(negedge clk);
        if (cmp) compare_all();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input bit v, input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                           input bit j, input bit ptk, input logic [31:0] ptg, input logic [3:0] g);
        upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg;
        upd_is_jump = j; upd_pred_taken = ptk; upd_pred_target = ptg; upd_ghr = g;
    endtask

    logic [31:0] pool [8];

    initial begin
        pool = '{32'h40, 32'h440, 32'h80, 32'h84, 32'h1000, 32'h1044, 32'hFFFF_FFFC, 32'h2040};
        rst = 1'b1; lk_pc = 32'h40;
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        tick(0);
        rst = 1'b0;

        // Reset state
        #2;
        chk("rst_hit", 32'(hit[0]), 0);
        chk("rst_taken", 32'(taken[0]), 0);
        chk("rst_target", tgt[0], 32'h44);
        chk("rst_slook", slook[0], 0);
        chk("rst_smis", smis[0], 0);
        tick(1);

        // Allocate on taken miss
        set_upd(1, 32'h40, 1, 32'h100, 0, 0, 0, 0);
        #2; chk("alloc_misp", 32'(misp[0]), 1);
        tick(1);
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("alloc_hit", 32'(hit[0]), 1);
        chk("alloc_taken", 32'(taken[0]), 1);
        chk("alloc_target", tgt[0], 32'h100);
        chk("alloc_smis", smis[0], 1);
        tick(1);

        // Saturate down, then one step back up
        for (int n = 0; n < 4; n++) begin
            set_upd(1, 32'h40, 0, 0, 0, 1, 32'h100, 0);
            tick(1);
        end
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("sat_hit", 32'(hit[0]), 1);
        chk("sat_taken", 32'(taken[0]), 0);
        chk("sat_target", tgt[0], 32'h44);
        tick(1);
        set_upd(1, 32'h40, 1, 32'h100, 0, 0, 0, 0);
        tick(1);
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("up1_hit", 32'(hit[0]), 1);
        chk("up1_taken", 32'(taken[0]), 0);
        tick(1);

        // Alias: same index, different tag replaces the entry
        set_upd(1, 32'h440, 1, 32'h300, 0, 0, 0, 0);
        tick(1);
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2; chk("alias_old_hit", 32'(hit[0]), 0);
        tick(1);
        lk_pc = 32'h440;
        #2;
        chk("alias_new_hit", 32'(hit[0]), 1);
        chk("alias_new_target", tgt[0], 32'h300);
        tick(1);

        // Same-cycle lookup and update: read before write
        lk_pc = 32'h80;
        set_upd(1, 32'h80, 1, 32'h200, 0, 0, 0, 0);
        #2; chk("rbw_pre_hit", 32'(hit[0]), 0);
        tick(1);
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rbw_post_hit", 32'(hit[0]), 1);
        chk("rbw_post_target", tgt[0], 32'h200);
        tick(1);

        // GHR shifting and repair on the gshare instance
        rst = 1'b1; tick(1); rst = 1'b0;
        lk_pc = 32'h100;
        set_upd(1, 32'h100, 1, 32'h500, 0, 1, 32'h500, 4'd0); tick(1);
        set_upd(1, 32'h100, 1, 32'h500, 0, 1, 32'h500, 4'd1); tick(1);
        set_upd(1, 32'h100, 1, 32'h500, 0, 1, 32'h500, 4'd3); tick(1);
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2; chk("gs_ghr7", 32'(ghr[1]), 32'h7);
        tick(1);
        set_upd(1, 32'h100, 0, 32'h500, 0, 1, 32'h500, 4'd1);
        #2; chk("gs_misp", 32'(misp[1]), 1);
        tick(1);
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2; chk("gs_repair", 32'(ghr[1]), 32'h2);
        tick(1);
        rst = 1'b1;
        set_upd(1, 32'h100, 1, 32'h600, 0, 0, 0, 4'd2);
        tick(1);
        rst = 1'b0;
        set_upd(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("gs_rst_ghr", 32'(ghr[1]), 0);
        chk("gs_rst_hit", 32'(hit[1]), 0);
        tick(1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit tk;
            rst   = ($urandom_range(0, 99) == 0);
            lk_pc = pool[$urandom_range(0, 7)];
            tk    = $urandom_range(0, 1);
            set_upd($urandom_range(0, 1), pool[$urandom_range(0, 7)], tk,
                    pool[$urandom_range(0, 7)] + 32'h100, ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 1), 32'h0,
                    $urandom_range(0, 1) ? 4'(m_ghr[1]) : 4'($urandom_range(0, 15)));
            upd_pred_target = $urandom_range(0, 1) ? upd_target : pool[$urandom_range(0, 7)];
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
